// File: rtl/bin_to_bcd_4digit_pkg.sv
// Shared constants and FSM encoding for the binary-to-BCD display converter.
package bin_to_bcd_4digit_pkg;

   localparam int unsigned BCD_MAX    = 9999;
   localparam int unsigned BCD_DIGITS = 4;
   localparam int unsigned BCD_WIDTH  = 4 * BCD_DIGITS;

   // 2'd3 is unreachable; the FSM recovers from it to ST_IDLE.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/bin_to_bcd_4digit_add3.sv
// Double-dabble nibble corrector: adds 3 to any digit of 5 or more before the shift.
module bin_to_bcd_4digit_add3 (
   input  logic [3:0] i_nibble,
   output logic [3:0] o_nibble
);

   // Inputs never exceed 9, so the 4-bit sum cannot carry out.
   always_comb begin
      o_nibble = (i_nibble >= 4'd5) ? i_nibble + 4'd3 : i_nibble;
   end

endmodule

// File: rtl/bin_to_bcd_4digit.sv
// Sequential double-dabble converter: unsigned binary -> four held BCD digits,
// saturating at 9999 with an overflow flag. Digits only change on completion.
module bin_to_bcd_4digit
   import bin_to_bcd_4digit_pkg::*;
#(
   parameter int unsigned IN_WIDTH = 14
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_start,
   input  logic [IN_WIDTH-1:0] i_value,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_overflow,
   output logic [3:0]          o_units,
   output logic [3:0]          o_tens,
   output logic [3:0]          o_hundreds,
   output logic [3:0]          o_thousands
);

   localparam int unsigned CNT_W = $clog2(IN_WIDTH);

   state_t                          state_q;
   logic [IN_WIDTH-1:0]             shift_q;
   logic [BCD_WIDTH-1:0]            scratch_q;
   logic [CNT_W-1:0]                cnt_q;
   logic                            ovf_pend_q;

   logic [BCD_WIDTH-1:0]            scratch_adj;
   logic [BCD_WIDTH+IN_WIDTH-1:0]   shifted;
   logic [BCD_WIDTH-1:0]            scratch_nxt;
   logic [IN_WIDTH-1:0]             shift_nxt;
   logic                            in_over;
   logic [IN_WIDTH-1:0]             in_sat;

   for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_add3
      bin_to_bcd_4digit_add3 u_add3 (
         .i_nibble (scratch_q[4*d +: 4]),
         .o_nibble (scratch_adj[4*d +: 4])
      );
   end

   // Narrower inputs cannot exceed 9999, so saturation only exists at full width.
   if (IN_WIDTH >= 14) begin : g_sat
      assign in_over = (i_value > IN_WIDTH'(BCD_MAX));
      assign in_sat  = in_over ? IN_WIDTH'(BCD_MAX) : i_value;
   end else begin : g_no_sat
      assign in_over = 1'b0;
      assign in_sat  = i_value;
   end

   // Corrected scratch and remaining binary shift left together as one word.
   always_comb begin
      shifted     = {scratch_adj, shift_q} << 1;
      scratch_nxt = shifted[BCD_WIDTH+IN_WIDTH-1:IN_WIDTH];
      shift_nxt   = shifted[IN_WIDTH-1:0];
   end

   // Busy covers both the shifting phase and the completion cycle.
   always_comb begin
      o_busy = (state_q == ST_SHIFT) || (state_q == ST_DONE);
   end

   // FSM, datapath registers and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         scratch_q   <= '0;
         cnt_q       <= '0;
         ovf_pend_q  <= 1'b0;
         o_done      <= 1'b0;
         o_overflow  <= 1'b0;
         o_units     <= 4'd0;
         o_tens      <= 4'd0;
         o_hundreds  <= 4'd0;
         o_thousands <= 4'd0;
      end else begin
         o_done <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (i_start) begin
                  shift_q    <= in_sat;
                  scratch_q  <= '0;
                  cnt_q      <= '0;
                  ovf_pend_q <= in_over;
                  state_q    <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               scratch_q <= scratch_nxt;
               shift_q   <= shift_nxt;
               if (cnt_q == CNT_W'(IN_WIDTH - 1)) begin
                  // Publish the post-shift scratch so the last bit is included.
                  o_units     <= scratch_nxt[3:0];
                  o_tens      <= scratch_nxt[7:4];
                  o_hundreds  <= scratch_nxt[11:8];
                  o_thousands <= scratch_nxt[15:12];
                  o_overflow  <= ovf_pend_q;
                  o_done      <= 1'b1;
                  state_q     <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_4digit.sv
// Self-checking bench for bin_to_bcd_4digit: directed cases plus a random sweep
// checked against an arithmetic decimal-digit model.
module tb_bin_to_bcd_4digit;

   localparam int unsigned W = 14;

   logic         i_clk   = 1'b0;
   logic         i_rst_n = 1'b0;
   logic         i_start = 1'b0;
   logic [W-1:0] i_value = '0;
   logic         o_busy;
   logic         o_done;
   logic         o_overflow;
   logic [3:0]   o_units;
   logic [3:0]   o_tens;
   logic [3:0]   o_hundreds;
   logic [3:0]   o_thousands;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   // Last result the DUT should be holding.
   int held_u  = 0;
   int held_t  = 0;
   int held_h  = 0;
   int held_th = 0;
   int held_ov = 0;

   bin_to_bcd_4digit #(.IN_WIDTH(W)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_start     (i_start),
      .i_value     (i_value),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_overflow  (o_overflow),
      .o_units     (o_units),
      .o_tens      (o_tens),
      .o_hundreds  (o_hundreds),
      .o_thousands (o_thousands)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Decimal digits of the saturated value, by plain division.
   task automatic model(input int v, output int u, output int t, output int h,
                        output int th, output int ov);
      int s;
      ov = (v > 9999) ? 1 : 0;
      s  = (v > 9999) ? 9999 : v;
      u  = s % 10;
      t  = (s / 10) % 10;
      h  = (s / 100) % 10;
      th = s / 1000;
   endtask

   task automatic chk_held(input string tag);
      chk({tag, "_u"},  32'(o_units),     held_u);
      chk({tag, "_t"},  32'(o_tens),      held_t);
      chk({tag, "_h"},  32'(o_hundreds),  held_h);
      chk({tag, "_th"}, 32'(o_thousands), held_th);
      chk({tag, "_ov"}, 32'(o_overflow),  held_ov);
   endtask

   // One conversion; noisy adds stray starts (value 77) at T+5 and in the DONE cycle.
   task automatic convert(input int v, input bit noisy);
      int u, t, h, th, ov;
      bit seen;
      model(v, u, t, h, th, ov);
      @(negedge i_clk);
      i_start = 1'b1;
      i_value = W'(v);
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      i_value = W'($urandom);
      chk("busy_after_start", 32'(o_busy), 1);
      seen = 1'b0;
      // k counts edges after the start edge; the cycle following edge T+k is cycle T+k+1.
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(negedge i_clk);
         if (noisy && k == 5) begin
            i_start = 1'b1;
            i_value = W'(77);
         end
         @(posedge i_clk);
         #1;
         i_start = 1'b0;
         if (k == 7) chk_held("hold_mid");
         if (o_done) begin
            seen = 1'b1;
            chk("latency", k + 1, W + 1);
         end
      end
      if (!seen) chk("done_timeout", 0, 1);
      held_u  = u;
      held_t  = t;
      held_h  = h;
      held_th = th;
      held_ov = ov;
      chk_held("result");
      chk("busy_in_done", 32'(o_busy), 1);
      @(negedge i_clk);
      if (noisy) begin
         i_start = 1'b1;
         i_value = W'(77);
      end
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      chk("done_one_cycle", 32'(o_done), 0);
      chk("idle_after_done", 32'(o_busy), 0);
      @(posedge i_clk);
      #1;
      chk("stray_start_ignored", 32'(o_busy), 0);
      chk_held("hold_idle");
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge i_clk);
      #1;
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_done", 32'(o_done), 0);
      chk_held("rst");
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // Basic conversion and latency
      convert(1234, 1'b0);

      // Range extremes
      convert(0, 1'b0);
      convert(9999, 1'b0);

      // Saturation, then a normal value clears the flag
      convert(16383, 1'b0);
      convert(10000, 1'b0);
      convert(5, 1'b0);

      // Starts while busy are dropped
      convert(42, 1'b1);

      // Reset in the middle of a conversion
      @(negedge i_clk);
      i_start = 1'b1;
      i_value = W'(5678);
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      repeat (6) @(posedge i_clk);
      #2;
      i_rst_n = 1'b0;
      #1;
      held_u  = 0;
      held_t  = 0;
      held_h  = 0;
      held_th = 0;
      held_ov = 0;
      chk("midrst_busy", 32'(o_busy), 0);
      chk("midrst_done", 32'(o_done), 0);
      chk_held("midrst");
      repeat (3) begin
         @(posedge i_clk);
         #1;
         chk("midrst_no_done", 32'(o_done), 0);
      end
      @(negedge i_clk);
      i_rst_n = 1'b1;
      convert(321, 1'b0);

      // Random sweep over the full input range
      for (int n = 0; n < 25; n++) begin
         convert(int'($urandom_range(16383, 0)), 1'(n % 4 == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
